rshift_seq: RTL and testbench

- Multi-cycle right-shift unit for the MIPS datapath, covering SRL, SRA, SRLV and SRAV. It is the right-direction counterpart of the fixed left-shift used for branch offsets.
- Shifts one bit per cycle under a valid/ready handshake.
- Sits in the EX stage beside the ALU. The pipeline stalls on busy; flush aborts an in-flight shift on branch or exception.

---
 rtl/rshift_pkg.sv | 32 +++
 rtl/rshift1.sv | 24 ++
 rtl/rshift_seq.sv | 152 +++++++++++++++
 tb/tb_rshift_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rshift_pkg.sv
// Shared types and constants for the multi-cycle right-shift unit.
package rshift_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Shift-type encoding carried on in_arith
   localparam logic OP_SRL = 1'b0;
   localparam logic OP_SRA = 1'b1;

   // MIPS funct codes of the right shifts
   localparam logic [5:0] SRL  = 6'h02;
   localparam logic [5:0] SRA  = 6'h03;
   localparam logic [5:0] SRLV = 6'h06;
   localparam logic [5:0] SRAV = 6'h07;

   // Decoder helper: funct code to in_arith value
   function automatic logic funct_is_arith(input logic [5:0] funct);
      logic arith_v;
      case (funct)
         SRA, SRAV: arith_v = OP_SRA;
         SRL, SRLV: arith_v = OP_SRL;
         default:   arith_v = OP_SRL;
      endcase
      return arith_v;
   endfunction

endpackage

// File: rtl/rshift1.sv
// Combinational single-bit right shift; arith selects sign fill over zero fill.
module rshift1 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d,
   input  logic             arith,
   output logic [WIDTH-1:0] q
);
   import rshift_pkg::*;

   logic fill_s;

   // Pick the fill bit and shift one position toward the LSB
   always_comb begin
      fill_s = 1'b0;
      if (arith == OP_SRA) begin
         fill_s = d[WIDTH-1];
      end else begin
         fill_s = 1'b0;
      end
      q = {fill_s, d[WIDTH-1:1]};
   end

endmodule

// File: rtl/rshift_seq.sv
// Multi-cycle right shifter (SRL/SRA/SRLV/SRAV), one bit per cycle,
// valid/ready on both sides, flush aborts any in-flight operation.
module rshift_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_arith,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy
);
   import rshift_pkg::*;

   localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
   localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

   state_t               state_r;
   state_t               state_nxt_s;
   logic [WIDTH-1:0]     data_r;
   logic [SHAMT_W-1:0]   cnt_r;
   logic                 arith_r;
   logic [WIDTH-1:0]     step_s;
   logic                 accept_s;
   logic                 in_ready_r;
   logic                 out_valid_r;
   logic                 busy_r;
   logic                 in_ready_nxt_s;
   logic                 out_valid_nxt_s;
   logic                 busy_nxt_s;

   rshift1 #(.WIDTH(WIDTH)) u_step (
      .d     (data_r),
      .arith (arith_r),
      .q     (step_s)
   );

   // A request is taken only in IDLE and never in a flush cycle
   assign accept_s  = in_valid && in_ready_r && !flush;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_data  = data_r;

   // State and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= in_ready_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

   // Next-state decode; flush always returns to IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid && !flush) begin
               if (in_shamt == CNT_ZERO) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = SHIFT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (flush) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == CNT_ONE) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         DONE: begin
            if (flush || out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode of the next state so outputs come straight from flops
   always_comb begin
      in_ready_nxt_s  = 1'b0;
      out_valid_nxt_s = 1'b0;
      busy_nxt_s      = 1'b0;
      case (state_nxt_s)
         IDLE: begin
            in_ready_nxt_s  = 1'b1;
            out_valid_nxt_s = 1'b0;
            busy_nxt_s      = 1'b0;
         end
         SHIFT: begin
            in_ready_nxt_s  = 1'b0;
            out_valid_nxt_s = 1'b0;
            busy_nxt_s      = 1'b1;
         end
         DONE: begin
            in_ready_nxt_s  = 1'b0;
            out_valid_nxt_s = 1'b1;
            busy_nxt_s      = 1'b1;
         end
         default: begin
            in_ready_nxt_s  = 1'b0;
            out_valid_nxt_s = 1'b0;
            busy_nxt_s      = 1'b1;
         end
      endcase
   end

   // Operand load, one shift step per SHIFT cycle, hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r  <= {WIDTH{1'b0}};
         cnt_r   <= CNT_ZERO;
         arith_r <= 1'b0;
      end else if (accept_s) begin
         data_r  <= in_data;
         cnt_r   <= in_shamt;
         arith_r <= in_arith;
      end else if ((state_r == SHIFT) && !flush && (cnt_r != CNT_ZERO)) begin
         data_r  <= step_s;
         cnt_r   <= cnt_r - CNT_ONE;
      end else begin
         data_r  <= data_r;
         cnt_r   <= cnt_r;
         arith_r <= arith_r;
      end
   end

endmodule

// File: tb/tb_rshift_seq.sv
// Directed bench for rshift_seq with a queue scoreboard and an
// independent monitor that checks result data and first-valid cycle.
module tb_rshift_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        in_arith;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   typedef struct {
      logic [31:0] data;
      int          rise;
   } exp_t;

   exp_t sb_q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   rshift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_arith  (in_arith),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Count rising edges; cyc==k right after edge k
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: event not seen / unexpected (cycle %0d)", name, cyc);
   endtask

   // Present a request, hold it until taken, record expected result/latency
   task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a,
                        input logic [31:0] exp, input bit expect_out);
      int   n;
      int   t_acc;
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_arith = a;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         fail_now("accept_timeout");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      t_acc = cyc - 1;
      if (expect_out) begin
         e.data = exp;
         e.rise = t_acc + int'(s) + 1;
         sb_q.push_back(e);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy !== 1'b0) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) fail_now("drain_timeout");
   endtask

   // Monitor: latency on out_valid rise, data on each accepted transfer
   initial begin : monitor
      logic prev_ov;
      exp_t e;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1 && !prev_ov) begin
            if (sb_q.size() == 0) fail_now("unexpected_out_valid");
            else chk("latency_cycle", 32'(cyc), 32'(sb_q[0].rise));
         end
         if (out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0 && rst === 1'b0) begin
            if (sb_q.size() == 0) begin
               fail_now("unexpected_transfer");
            end else begin
               e = sb_q.pop_front();
               chk("result", out_data, e.data);
            end
         end
         prev_ov = (out_valid === 1'b1);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0;
      in_shamt = 5'd0; in_arith = 1'b0; out_ready = 1'b1;

      // Reset values
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic SRL/SRA vectors, including shamt 0 and 31
      issue(32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 1'b1); drain();
      issue(32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 1'b1); drain();
      issue(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1); drain();
      issue(32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1'b1); drain();
      issue(32'hF0F0_F0F0, 5'd8,  1'b0, 32'h00F0_F0F0, 1'b1); drain();
      issue(32'hF0F0_F0F0, 5'd8,  1'b1, 32'hFFF0_F0F0, 1'b1); drain();
      issue(32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 1'b1); drain();

      // Backpressure: result held for 10 cycles with out_ready low
      out_ready = 1'b0;
      issue(32'hA5A5_A5A5, 5'd3, 1'b1, 32'hF4B4_B4B4, 1'b1);
      begin
         int n;
         n = 0;
         while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) fail_now("bp_valid_timeout");
      end
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_out_data", out_data, 32'hF4B4_B4B4);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      drain();

      // Second request held while busy is taken only after returning to IDLE
      issue(32'h8000_0000, 5'd8, 1'b0, 32'h0080_0000, 1'b1);
      issue(32'hFFFF_0000, 5'd4, 1'b1, 32'hFFFF_F000, 1'b1);
      drain();

      // Flush in the second shift cycle of a shamt 8 operation
      issue(32'h0000_FF00, 5'd8, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 12; i++) begin
         chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;

      // Reset in the third shift cycle of a shamt 8 operation
      issue(32'h1357_9BDF, 5'd8, 1'b1, 32'h0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_out_data", out_data, 32'h0);
      for (int i = 0; i < 12; i++) begin
         chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;

      // Normal operation resumes afterwards
      issue(32'h0F0F_0F0F, 5'd1, 1'b0, 32'h0787_8787, 1'b1); drain();

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
